disp_value_loader: RTL and testbench

- Upstream feeder for the 8-digit seven-segment display controller.
- Accepts a binary value on a start strobe and converts it to 8 BCD digits with a sequential double-dabble (one shift per clock).
- Then drives the controller's digit-write interface (write/num/sel), one digit per clock, ones digit at sel 0.
- Lets software and other logic update the display with a single strobe instead of eight manual writes.

---
 rtl/disp_value_loader.sv | 136 +++++++++++++
 tb/tb_disp_value_loader.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/disp_value_loader.sv
// Binary-to-BCD loader for the 8-digit seven-segment controller: serial double-dabble, then one digit write per clock.
// Optional `DISP_HEX_MODE_EN adds a hex_mode input that skips conversion and writes the raw nibbles of value.
module disp_value_loader #(
  parameter int DIGITS = 8,
  parameter int IN_W   = 27
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [IN_W-1:0]           value,
`ifdef DISP_HEX_MODE_EN
  input  logic                      hex_mode,
`endif
  output logic                      busy,
  output logic                      done,
  output logic                      ovf,
  output logic                      write,
  output logic [3:0]                num,
  output logic [$clog2(DIGITS)-1:0] sel
);

  localparam int SEL_W = $clog2(DIGITS);
  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_W);
  localparam logic [63:0]      MAX_VAL  = 64'(10 ** DIGITS) - 64'd1;
  localparam logic [BCD_W-1:0] NINES    = {DIGITS{4'h9}};
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, CONVERT, WRITE, DONE} state_t;

  state_t             state, state_nxt;
  logic [IN_W-1:0]    bin;
  logic [BCD_W-1:0]   bcd;
  logic [CNT_W-1:0]   bit_cnt;
  logic               hex_go;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W+IN_W-1:0] dd_next;
  logic [BCD_W-1:0]   bcd_shift;
  logic [BCD_W-1:0]   bcd_final;

`ifdef DISP_HEX_MODE_EN
  assign hex_go = hex_mode;
`else
  assign hex_go = 1'b0;
`endif

  // Double-dabble step: bias nibbles >= 5 by 3, then shift {bcd,bin} left one place.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  assign dd_next   = {bcd_adj, bin} << 1;
  assign bcd_shift = dd_next[BCD_W+IN_W-1:IN_W];
  assign bcd_final = ovf ? NINES : bcd_shift;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = hex_go ? WRITE : CONVERT;
      CONVERT: if (bit_cnt == '0) state_nxt = WRITE;
      WRITE:   if (sel == SEL_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy  = 1'b0;
    write = 1'b0;
    done  = 1'b0;
    case (state)
      CONVERT: busy = 1'b1;
      WRITE:   begin busy = 1'b1; write = 1'b1; end
      DONE:    begin busy = 1'b1; done  = 1'b1; end
      default: ;
    endcase
  end

  // bcd doubles as the output shifter during WRITE: num always takes the next low nibble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bin     <= '0;
      bcd     <= '0;
      bit_cnt <= '0;
      ovf     <= 1'b0;
      num     <= '0;
      sel     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (hex_go) begin
              ovf <= 1'b0;
              num <= value[3:0];
              bcd <= BCD_W'(value) >> 4;
              sel <= '0;
            end else begin
              ovf     <= (64'(value) > MAX_VAL);
              bin     <= value;
              bcd     <= '0;
              bit_cnt <= CNT_W'(IN_W - 1);
            end
          end
        end
        CONVERT: begin
          bit_cnt <= bit_cnt - 1'b1;
          bin     <= dd_next[IN_W-1:0];
          if (bit_cnt == '0) begin
            num <= bcd_final[3:0];
            bcd <= bcd_final >> 4;
            sel <= '0;
          end else begin
            bcd <= bcd_shift;
          end
        end
        WRITE: begin
          if (sel != SEL_LAST) begin
            sel <= sel + 1'b1;
            num <= bcd[3:0];
            bcd <= bcd >> 4;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_disp_value_loader.sv
// Randomized self-checking bench for disp_value_loader against a division-based digit model.
`timescale 1ns/1ps
module tb_disp_value_loader;
  localparam int DIGITS  = 8;
  localparam int IN_W    = 27;
  localparam int LAT_DEC = IN_W + DIGITS + 1;
  localparam int LAT_HEX = DIGITS + 1;
  localparam longint MAXV = 64'd10 ** DIGITS - 1;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [IN_W-1:0] value = '0;
`ifdef DISP_HEX_MODE_EN
  logic            hex_mode = 1'b0;
`endif
  logic            busy, done, ovf, write;
  logic [3:0]      num;
  logic [2:0]      sel;

  int total = 0;
  int bad = 0;
  int wr_sel[$];
  int wr_num[$];
  int wr_cyc[$];
  int ndone, done_at, nbusy;

  disp_value_loader #(.DIGITS(DIGITS), .IN_W(IN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .value(value),
`ifdef DISP_HEX_MODE_EN
    .hex_mode(hex_mode),
`endif
    .busy(busy), .done(done), .ovf(ovf), .write(write), .num(num), .sel(sel)
  );

  always #5 clk = ~clk;

  function automatic int exp_digit(input longint v, input bit hx, input int i);
    if (hx) return int'((v >> (4 * i)) & 64'd15);
    if (v > MAXV) return 9;
    return int'((v / (64'd10 ** i)) % 64'd10);
  endfunction

  // Issues one start and records every write / done / busy cycle for 45 cycles after accept.
  task automatic run_op(input logic [IN_W-1:0] v, input bit hx, input int p1, input int p2);
    wr_sel.delete(); wr_num.delete(); wr_cyc.delete();
    ndone = 0; done_at = -1; nbusy = 0;
    @(negedge clk);
    start = 1'b1;
    value = v;
`ifdef DISP_HEX_MODE_EN
    hex_mode = hx;
`else
    if (hx) $display("note: hex request issued without hex build");
`endif
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      start = (k == p1) || (k == p2);
      value = IN_W'($urandom);
      if (write) begin
        wr_sel.push_back(int'(sel)); wr_num.push_back(int'(num)); wr_cyc.push_back(k);
      end
      if (done) begin ndone++; done_at = k; end
      if (busy) nbusy++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    start = 1'b1;
    value = 27'd12345678;
    @(negedge clk);
    total++;
    if ({busy, done, ovf, write, num, sel} !== 11'd0) begin
      bad++; $display("FAIL reset_outputs got=%b exp=0", {busy, done, ovf, write, num, sel});
    end
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_release_busy got=%b exp=0", busy); end
  endtask

  task automatic test_decimal();
    logic [IN_W-1:0] vals[$];
    vals = '{27'd12345678, 27'd0, 27'd99999999, 27'd100000000, 27'd5, 27'h7FFFFFF, 27'd87654321};
    for (int r = 0; r < 6; r++) vals.push_back(IN_W'($urandom));
    vals.push_back(27'd99999999 - IN_W'($urandom_range(0, 50)));
    foreach (vals[n]) begin
      longint v = longint'(vals[n]);
      run_op(vals[n], 1'b0, 0, 0);
      total++;
      if (wr_sel.size() != DIGITS) begin bad++; $display("FAIL dec_nwrites v=%0d got=%0d exp=%0d", v, wr_sel.size(), DIGITS); end
      total++;
      if (ndone != 1 || done_at != LAT_DEC) begin
        bad++; $display("FAIL dec_done v=%0d got=%0d@%0d exp=1@%0d", v, ndone, done_at, LAT_DEC);
      end
      total++;
      if (nbusy != LAT_DEC) begin bad++; $display("FAIL dec_busy v=%0d got=%0d exp=%0d", v, nbusy, LAT_DEC); end
      total++;
      if (ovf !== (v > MAXV)) begin bad++; $display("FAIL dec_ovf v=%0d got=%b exp=%b", v, ovf, v > MAXV); end
      for (int i = 0; i < wr_sel.size() && i < DIGITS; i++) begin
        total++;
        if (wr_sel[i] != i || wr_num[i] != exp_digit(v, 1'b0, i) || wr_cyc[i] != LAT_DEC - DIGITS + i) begin
          bad++;
          $display("FAIL dec_write v=%0d i=%0d got=(sel %0d,num %0d,cyc %0d) exp=(%0d,%0d,%0d)",
                   v, i, wr_sel[i], wr_num[i], wr_cyc[i], i, exp_digit(v, 1'b0, i), LAT_DEC - DIGITS + i);
        end
      end
    end
  endtask

  task automatic test_ovf_sticky();
    run_op(27'd100000000, 1'b0, 0, 0);
    repeat (5) @(negedge clk);
    total++;
    if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", ovf); end
    run_op(27'd5, 1'b0, 0, 0);
    total++;
    if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", ovf); end
    total++;
    if (wr_num.size() != DIGITS || wr_num[0] != 5 || wr_num[1] != 0 || wr_num[7] != 0) begin
      bad++; $display("FAIL ovf_next_digits got_n=%0d first=%0d exp_n=8 first=5", wr_num.size(),
                      wr_num.size() > 0 ? wr_num[0] : -1);
    end
  endtask

  task automatic test_ignore_start();
    run_op(IN_W'($urandom_range(0, 99999999)), 1'b0, 5, 20);
    total++;
    if (wr_sel.size() != DIGITS || ndone != 1) begin
      bad++; $display("FAIL busy_start_writes got=%0d/%0d exp=%0d/1", wr_sel.size(), ndone, DIGITS);
    end
    run_op(IN_W'($urandom_range(0, 99999999)), 1'b0, 20, LAT_DEC);
    total++;
    if (nbusy != LAT_DEC || ndone != 1) begin
      bad++; $display("FAIL done_cycle_start got_busy=%0d done=%0d exp=%0d/1", nbusy, ndone, LAT_DEC);
    end
  endtask

  task automatic test_reset_mid_write();
    int seen = 0;
    int after = 0;
    int hi = 0;
    @(negedge clk);
    start = 1'b1;
    value = 27'd100000000;
    for (int k = 0; k < 60 && seen < 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (write) seen++;
    end
    total++;
    if (seen != 3 || ovf !== 1'b1 || num !== 4'd9) begin
      bad++; $display("FAIL pre_reset_state got=writes %0d ovf %b num %0d exp=3 1 9", seen, ovf, num);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({busy, done, ovf, write, num, sel} !== 11'd0) begin
      bad++; $display("FAIL async_reset got=%b exp=0", {busy, done, ovf, write, num, sel});
    end
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (write) after++;
      if (busy) hi++;
    end
    total++;
    if (after != 0 || hi != 0) begin bad++; $display("FAIL post_reset_quiet got=writes %0d busy %0d exp=0 0", after, hi); end
    run_op(27'd12345678, 1'b0, 0, 0);
    total++;
    if (wr_num.size() != DIGITS || wr_num[0] != 8 || wr_num[7] != 1) begin
      bad++; $display("FAIL post_reset_op got_n=%0d exp=8 writes 8..1", wr_num.size());
    end
  endtask

`ifdef DISP_HEX_MODE_EN
  task automatic test_hex();
    logic [IN_W-1:0] vals[$];
    vals = '{27'h3ABCDEF, 27'h7FFFFFF, IN_W'($urandom), IN_W'($urandom)};
    foreach (vals[n]) begin
      longint v = longint'(vals[n]);
      run_op(vals[n], 1'b1, 0, 0);
      total++;
      if (wr_sel.size() != DIGITS || ndone != 1 || done_at != LAT_HEX || ovf !== 1'b0) begin
        bad++; $display("FAIL hex_frame v=%0h got=n%0d done%0d@%0d ovf%b exp=n%0d done1@%0d ovf0",
                        v, wr_sel.size(), ndone, done_at, ovf, DIGITS, LAT_HEX);
      end
      for (int i = 0; i < wr_sel.size() && i < DIGITS; i++) begin
        total++;
        if (wr_sel[i] != i || wr_num[i] != exp_digit(v, 1'b1, i) || wr_cyc[i] != LAT_HEX - DIGITS + i) begin
          bad++; $display("FAIL hex_write v=%0h i=%0d got=(%0d,%0h,%0d) exp=(%0d,%0h,%0d)", v, i,
                          wr_sel[i], wr_num[i], wr_cyc[i], i, exp_digit(v, 1'b1, i), LAT_HEX - DIGITS + i);
        end
      end
    end
    run_op(27'd100000000, 1'b0, 0, 0);
    total++;
    if (ovf !== 1'b1 || done_at != LAT_DEC) begin
      bad++; $display("FAIL hex_off_decimal got=ovf %b done@%0d exp=1 @%0d", ovf, done_at, LAT_DEC);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_decimal();
    test_ovf_sticky();
    test_ignore_start();
    test_reset_mid_write();
`ifdef DISP_HEX_MODE_EN
    test_hex();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
